// File: rtl/sram_top.sv
// Behavioural front-end and array model for the mixed-signal SRAM macro:
// serial MSB-first word loading, row write, and registered row read with a valid strobe.
module sram_top #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            serial_in,
  input  logic            shift,
  input  logic            w_en,
  input  logic            r_en,
  input  logic [ROWS-1:0] addr,
  output logic [COLS-1:0] data_out,
  output logic            data_valid
);

  localparam int DEPTH = 2 ** ROWS;

  logic [COLS-1:0] sreg_r;
  logic [COLS-1:0] sreg_shifted_s;
  logic [COLS-1:0] sreg_next_s;
  logic [COLS-1:0] mem_r [DEPTH];
  logic            rd_s;

  // A one-bit word has no upper bits to carry, so it simply takes the new bit.
  generate
    if (COLS == 1) begin : g_shift_one
      assign sreg_shifted_s = serial_in;
    end else begin : g_shift_many
      assign sreg_shifted_s = {sreg_r[COLS-2:0], serial_in};
    end
  endgenerate

  // Next shift-register value and read qualification; a write blocks a read.
  always_comb begin
    sreg_next_s = sreg_r;
    rd_s        = 1'b0;
    if (shift) begin
      sreg_next_s = sreg_shifted_s;
    end else begin
      sreg_next_s = sreg_r;
    end
    if (r_en && !w_en) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  // Input word register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sreg_r <= {COLS{1'b0}};
    end else begin
      sreg_r <= sreg_next_s;
    end
  end

  // Bitcell array; commits the pre-edge shift register contents.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {COLS{1'b0}};
      end
    end else if (w_en) begin
      mem_r[addr] <= sreg_r;
    end
  end

  // Registered read port with a one-cycle valid strobe per completed read.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_out   <= {COLS{1'b0}};
      data_valid <= 1'b0;
    end else if (rd_s) begin
      data_out   <= mem_r[addr];
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_top.sv
// Directed self-checking bench for sram_top (ROWS=4, COLS=8).
module tb_sram_top;

  logic       clk;
  logic       arst;
  logic       serial_in;
  logic       shift;
  logic       w_en;
  logic       r_en;
  logic [3:0] addr;
  logic [7:0] data_out;
  logic       data_valid;

  int total;
  int bad;

  sram_top #(.ROWS(4), .COLS(8)) dut (
    .clk       (clk),
    .arst      (arst),
    .serial_in (serial_in),
    .shift     (shift),
    .w_en      (w_en),
    .r_en      (r_en),
    .addr      (addr),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at a falling edge, let the rising edge act, return at the next falling edge.
  task automatic cycle(input logic sh, input logic si, input logic we, input logic re, input logic [3:0] a);
    shift = sh; serial_in = si; w_en = we; r_en = re; addr = a;
    @(negedge clk);
    shift = 1'b0; serial_in = 1'b0; w_en = 1'b0; r_en = 1'b0; addr = 4'd0;
  endtask

  task automatic shift_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cycle(1'b1, val[i], 1'b0, 1'b0, 4'd0);
    end
  endtask

  task automatic write_row(input logic [3:0] a);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, a);
  endtask

  task automatic read_row(input logic [3:0] a);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, a);
  endtask

  initial begin
    total = 0;
    bad = 0;
    arst = 1'b1;
    shift = 1'b0; serial_in = 1'b0; w_en = 1'b0; r_en = 1'b0; addr = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check_val("reset_dout", {8'h00, data_out}, 16'h0000);
    check_val("reset_valid", {15'd0, data_valid}, 16'h0000);
    arst = 1'b0;
    @(negedge clk);

    // Reset mid-stream: load a row, start another shift, then reset.
    shift_bits(16'h00FF, 8);
    write_row(4'd5);
    read_row(4'd5);
    check_val("pre_reset_rd5", {8'h00, data_out}, 16'h00FF);
    shift_bits(16'h0005, 3);
    arst = 1'b1;
    #1;
    check_val("async_reset_dout", {8'h00, data_out}, 16'h0000);
    check_val("async_reset_valid", {15'd0, data_valid}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    read_row(4'd5);
    check_val("post_reset_rd5", {8'h00, data_out}, 16'h0000);
    check_val("post_reset_rd5_valid", {15'd0, data_valid}, 16'h0001);
    write_row(4'd6);
    read_row(4'd6);
    check_val("post_reset_sreg_cleared", {8'h00, data_out}, 16'h0000);

    // Basic write/read with one-cycle valid.
    shift_bits(16'h00A5, 8);
    write_row(4'd1);
    read_row(4'd1);
    check_val("basic_rd1", {8'h00, data_out}, 16'h00A5);
    check_val("basic_valid_hi", {15'd0, data_valid}, 16'h0001);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("basic_valid_lo", {15'd0, data_valid}, 16'h0000);
    check_val("basic_hold", {8'h00, data_out}, 16'h00A5);

    // Address isolation and back-to-back reads.
    shift_bits(16'h003C, 8);
    write_row(4'd0);
    shift_bits(16'h00C3, 8);
    write_row(4'd15);
    check_val("write_keeps_dout", {8'h00, data_out}, 16'h00A5);
    check_val("write_keeps_valid", {15'd0, data_valid}, 16'h0000);
    read_row(4'd0);
    check_val("iso_rd0", {8'h00, data_out}, 16'h003C);
    check_val("iso_rd0_valid", {15'd0, data_valid}, 16'h0001);
    read_row(4'd15);
    check_val("iso_rd15", {8'h00, data_out}, 16'h00C3);
    check_val("iso_rd15_valid", {15'd0, data_valid}, 16'h0001);
    read_row(4'd1);
    check_val("iso_rd1", {8'h00, data_out}, 16'h00A5);

    // Overshift: 12 bits 0xF0A leaves the low 8 bits.
    shift_bits(16'h0F0A, 12);
    write_row(4'd2);
    read_row(4'd2);
    check_val("overshift_rd2", {8'h00, data_out}, 16'h000A);

    // Write/read collision: write wins, read dropped.
    shift_bits(16'h0055, 8);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    check_val("collide_valid", {15'd0, data_valid}, 16'h0000);
    check_val("collide_hold", {8'h00, data_out}, 16'h000A);
    read_row(4'd3);
    check_val("collide_rd3", {8'h00, data_out}, 16'h0055);

    // Shift on the write edge: row gets pre-edge 0x81, sreg becomes 0x03.
    shift_bits(16'h0081, 8);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd4);
    read_row(4'd4);
    check_val("shift_write_rd4", {8'h00, data_out}, 16'h0081);
    write_row(4'd7);
    read_row(4'd7);
    check_val("shift_write_sreg", {8'h00, data_out}, 16'h0003);

    // Undershift: four ones onto 0x03 gives 0x3F.
    shift_bits(16'h000F, 4);
    write_row(4'd8);
    read_row(4'd8);
    check_val("undershift_rd8", {8'h00, data_out}, 16'h003F);

    // Never-written row.
    read_row(4'd9);
    check_val("unwritten_rd9", {8'h00, data_out}, 16'h0000);
    check_val("unwritten_valid", {15'd0, data_valid}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
